// File: rtl/hsv_threshold_bbox.sv
// hsv_threshold_bbox
//   Classifies each HSV pixel (Q10.6) from the RGB565-to-HSV converter
//   against a programmable HSV window. Writes a 1-bit mask per pixel to the
//   mask BRAM, and publishes a per-frame bounding box and hit count.
//
// Ports
//   i_clk, i_rstn         clock, synchronous active-low reset
//   i_valid, i_addr       input pixel strobe and raster address
//   i_hue/i_sat/i_value   pixel HSV, unsigned Q10.6
//   i_cfg_load, i_cfg_*   capture window limits into shadow registers
//   o_mask_we/addr/data   mask BRAM write port (2 cycles after i_valid)
//   o_bbox_valid          1-cycle pulse: frame results updated
//   o_x_min..o_y_max      bounding box of hit pixels
//   o_count, o_detected   hit count (saturating) and count >= MIN_PIXELS
//
// Optional: define HSV_BBOX_CENTER_EN to add o_cx/o_cy (box centre).
module hsv_threshold_bbox #(
  parameter int unsigned BRAM_DEPTH = 230400,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned MIN_PIXELS = 64,
  localparam int unsigned IMG_HEIGHT = BRAM_DEPTH / IMG_WIDTH,
  localparam int unsigned AW = $clog2(BRAM_DEPTH),
  localparam int unsigned XW = $clog2(IMG_WIDTH),
  localparam int unsigned YW = $clog2(IMG_HEIGHT),
  localparam int unsigned CW = $clog2(BRAM_DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_hue,
  input  logic [15:0]   i_sat,
  input  logic [15:0]   i_value,
  input  logic          i_cfg_load,
  input  logic [15:0]   i_cfg_hue_lo,
  input  logic [15:0]   i_cfg_hue_hi,
  input  logic [15:0]   i_cfg_sat_min,
  input  logic [15:0]   i_cfg_val_min,
  output logic          o_mask_we,
  output logic [AW-1:0] o_mask_addr,
  output logic          o_mask_data,
  output logic          o_bbox_valid,
  output logic [XW-1:0] o_x_min,
  output logic [XW-1:0] o_x_max,
  output logic [YW-1:0] o_y_min,
  output logic [YW-1:0] o_y_max,
  output logic [CW-1:0] o_count,
  output logic          o_detected
`ifdef HSV_BBOX_CENTER_EN
  ,
  output logic [XW-1:0] o_cx,
  output logic [YW-1:0] o_cy
`endif
);

  localparam logic [15:0]   HUE_FULL  = 16'd23040;
  localparam logic [AW-1:0] ADDR_LAST = AW'(BRAM_DEPTH - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(BRAM_DEPTH);
  localparam logic [CW-1:0] CNT_MIN   = CW'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state;

  // Configuration: shadow captured on load, active swapped at frame start
  logic [15:0] sh_hue_lo, sh_hue_hi, sh_sat_min, sh_val_min;
  logic [15:0] ac_hue_lo, ac_hue_hi, ac_sat_min, ac_val_min;
  logic [15:0] ef_hue_lo, ef_hue_hi, ef_sat_min, ef_val_min;
  logic        frame_start;
  logic        hue_ok, hit_in;

  assign frame_start = i_valid && (i_addr == '0);

  // The addr-0 pixel itself is classified with the window it installs.
  always_comb begin
    ef_hue_lo  = frame_start ? sh_hue_lo  : ac_hue_lo;
    ef_hue_hi  = frame_start ? sh_hue_hi  : ac_hue_hi;
    ef_sat_min = frame_start ? sh_sat_min : ac_sat_min;
    ef_val_min = frame_start ? sh_val_min : ac_val_min;
    if (ef_hue_lo <= ef_hue_hi)
      hue_ok = (ef_hue_lo <= i_hue) && (i_hue <= ef_hue_hi);
    else
      hue_ok = (i_hue >= ef_hue_lo) || (i_hue <= ef_hue_hi); // wraps through 0 (red)
    hit_in = hue_ok && (i_sat >= ef_sat_min) && (i_value >= ef_val_min);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sh_hue_lo <= '0; sh_hue_hi <= HUE_FULL; sh_sat_min <= '0; sh_val_min <= '0;
      ac_hue_lo <= '0; ac_hue_hi <= HUE_FULL; ac_sat_min <= '0; ac_val_min <= '0;
    end else begin
      if (i_cfg_load) begin
        sh_hue_lo  <= i_cfg_hue_lo;
        sh_hue_hi  <= i_cfg_hue_hi;
        sh_sat_min <= i_cfg_sat_min;
        sh_val_min <= i_cfg_val_min;
      end
      if (frame_start) begin
        ac_hue_lo  <= sh_hue_lo;
        ac_hue_hi  <= sh_hue_hi;
        ac_sat_min <= sh_sat_min;
        ac_val_min <= sh_val_min;
      end
    end
  end

  // x/y position of the incoming pixel
  logic [XW-1:0] x_cnt, cur_x;
  logic [YW-1:0] y_cnt, cur_y;

  assign cur_x = frame_start ? '0 : x_cnt;
  assign cur_y = frame_start ? '0 : y_cnt;

  // Stage 1
  logic          s1_valid, s1_hit;
  logic [AW-1:0] s1_addr;
  logic [XW-1:0] s1_x, s2_x;
  logic [YW-1:0] s1_y, s2_y;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      s1_valid <= 1'b0; s1_hit <= 1'b0; s1_addr <= '0;
      s1_x <= '0; s1_y <= '0; x_cnt <= '0; y_cnt <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_addr <= i_addr;
        s1_hit  <= hit_in;
        s1_x    <= cur_x;
        s1_y    <= cur_y;
        if (cur_x == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= cur_y + YW'(1);
        end else begin
          x_cnt <= cur_x + XW'(1);
          y_cnt <= cur_y;
        end
      end
    end
  end

  // Stage 2: mask write port doubles as the accumulator's input pixel
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_mask_we <= 1'b0; o_mask_addr <= '0; o_mask_data <= 1'b0;
      s2_x <= '0; s2_y <= '0;
    end else begin
      o_mask_we   <= s1_valid;
      o_mask_addr <= s1_addr;
      o_mask_data <= s1_valid && s1_hit;
      s2_x        <= s1_x;
      s2_y        <= s1_y;
    end
  end

  // Accumulator next-values for the stage-2 pixel
  logic          start2, end2;
  logic [CW-1:0] acc_cnt, b_cnt, n_cnt;
  logic [XW-1:0] acc_xmin, acc_xmax, b_xmin, b_xmax, n_xmin, n_xmax;
  logic [YW-1:0] acc_ymin, acc_ymax, b_ymin, b_ymax, n_ymin, n_ymax;

  assign start2 = o_mask_we && (o_mask_addr == '0);
  assign end2   = o_mask_we && (o_mask_addr == ADDR_LAST);

  always_comb begin
    b_cnt = acc_cnt; b_xmin = acc_xmin; b_xmax = acc_xmax; b_ymin = acc_ymin; b_ymax = acc_ymax;
    if (start2) begin
      b_cnt = '0; b_xmin = '1; b_xmax = '0; b_ymin = '1; b_ymax = '0;
    end
    n_cnt = b_cnt; n_xmin = b_xmin; n_xmax = b_xmax; n_ymin = b_ymin; n_ymax = b_ymax;
    if (o_mask_we && o_mask_data) begin
      n_cnt  = (b_cnt == CNT_SAT) ? b_cnt : b_cnt + CW'(1);
      n_xmin = (s2_x < b_xmin) ? s2_x : b_xmin;
      n_xmax = (s2_x > b_xmax) ? s2_x : b_xmax;
      n_ymin = (s2_y < b_ymin) ? s2_y : b_ymin;
      n_ymax = (s2_y > b_ymax) ? s2_y : b_ymax;
    end
  end

  // Results are registered on the ACCUM->DONE transition from the
  // next-values, so o_bbox_valid is high during the DONE cycle itself.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= IDLE;
      acc_cnt <= '0; acc_xmin <= '1; acc_xmax <= '0; acc_ymin <= '1; acc_ymax <= '0;
      o_bbox_valid <= 1'b0; o_count <= '0; o_detected <= 1'b0;
      o_x_min <= '0; o_x_max <= '0; o_y_min <= '0; o_y_max <= '0;
`ifdef HSV_BBOX_CENTER_EN
      o_cx <= '0; o_cy <= '0;
`endif
    end else begin
      o_bbox_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start2) begin
            acc_cnt <= n_cnt; acc_xmin <= n_xmin; acc_xmax <= n_xmax;
            acc_ymin <= n_ymin; acc_ymax <= n_ymax;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (o_mask_we) begin
            acc_cnt <= n_cnt; acc_xmin <= n_xmin; acc_xmax <= n_xmax;
            acc_ymin <= n_ymin; acc_ymax <= n_ymax;
            if (end2 && !start2) begin
              state        <= DONE;
              o_bbox_valid <= 1'b1;
              o_count      <= n_cnt;
              o_detected   <= (n_cnt != '0) && (n_cnt >= CNT_MIN);
              if (n_cnt == '0) begin
                o_x_min <= '0; o_x_max <= '0; o_y_min <= '0; o_y_max <= '0;
`ifdef HSV_BBOX_CENTER_EN
                o_cx <= '0; o_cy <= '0;
`endif
              end else begin
                o_x_min <= n_xmin; o_x_max <= n_xmax;
                o_y_min <= n_ymin; o_y_max <= n_ymax;
`ifdef HSV_BBOX_CENTER_EN
                o_cx <= XW'(({1'b0, n_xmin} + {1'b0, n_xmax}) >> 1);
                o_cy <= YW'(({1'b0, n_ymin} + {1'b0, n_ymax}) >> 1);
`endif
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsv_threshold_bbox.sv
module tb_hsv_threshold_bbox;

  localparam int unsigned BD = 64;
  localparam int unsigned IW = 8;
  localparam int unsigned MP = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_valid;
  logic [5:0] i_addr;
  logic [15:0] i_hue, i_sat, i_value;
  logic       i_cfg_load;
  logic [15:0] i_cfg_hue_lo, i_cfg_hue_hi, i_cfg_sat_min, i_cfg_val_min;
  logic       o_mask_we, o_mask_data, o_bbox_valid, o_detected;
  logic [5:0] o_mask_addr;
  logic [2:0] o_x_min, o_x_max, o_y_min, o_y_max;
  logic [6:0] o_count;
`ifdef HSV_BBOX_CENTER_EN
  logic [2:0] o_cx, o_cy;
`endif

  always #5 clk = ~clk;

  hsv_threshold_bbox #(.BRAM_DEPTH(BD), .IMG_WIDTH(IW), .MIN_PIXELS(MP)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .i_addr(i_addr),
    .i_hue(i_hue), .i_sat(i_sat), .i_value(i_value),
    .i_cfg_load(i_cfg_load), .i_cfg_hue_lo(i_cfg_hue_lo), .i_cfg_hue_hi(i_cfg_hue_hi),
    .i_cfg_sat_min(i_cfg_sat_min), .i_cfg_val_min(i_cfg_val_min),
    .o_mask_we(o_mask_we), .o_mask_addr(o_mask_addr), .o_mask_data(o_mask_data),
    .o_bbox_valid(o_bbox_valid), .o_x_min(o_x_min), .o_x_max(o_x_max),
    .o_y_min(o_y_min), .o_y_max(o_y_max), .o_count(o_count), .o_detected(o_detected)
`ifdef HSV_BBOX_CENTER_EN
    , .o_cx(o_cx), .o_cy(o_cy)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = -1;
  int last_cyc = 0;

  typedef struct {int addr; bit hit; int due;} exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Mask write port and result pulse monitor
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cyc) begin
      check("mask_we", 32'(o_mask_we), 1);
      check("mask_addr", 32'(o_mask_addr), 32'(q[0].addr));
      check("mask_data", 32'(o_mask_data), 32'(q[0].hit));
      q.delete(0);
    end else if (o_mask_we === 1'b1) begin
      check("mask_we_unexpected", 32'(o_mask_we), 0);
    end
    if (o_bbox_valid === 1'b1) begin
      pulse_cnt++;
      pulse_cyc = cyc;
    end
  end

  task automatic pix(input int a, input int h, input int s, input int v,
                     input bit hit, input bit ld);
    @(posedge clk); #1;
    i_valid    = 1'b1;
    i_addr     = 6'(a);
    i_hue      = 16'(h);
    i_sat      = 16'(s);
    i_value    = 16'(v);
    i_cfg_load = ld;
    q.push_back('{addr: a, hit: hit, due: cyc + 2});
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_valid    = 1'b0;
      i_cfg_load = 1'b0;
    end
  endtask

  task automatic cfg(input int lo, input int hi, input int smin, input int vmin);
    @(posedge clk); #1;
    i_valid       = 1'b0;
    i_cfg_hue_lo  = 16'(lo);
    i_cfg_hue_hi  = 16'(hi);
    i_cfg_sat_min = 16'(smin);
    i_cfg_val_min = 16'(vmin);
    i_cfg_load    = 1'b1;
    @(posedge clk); #1;
    i_cfg_load    = 1'b0;
  endtask

  task automatic frame_result(input int cnt, input int xmn, input int xmx,
                              input int ymn, input int ymx, input bit det,
                              input int cx, input int cy);
    int exp_pulse;
    exp_pulse = last_cyc + 3;
    idle(6);
    check("pulse_cnt", 32'(pulse_cnt), 1);
    check("pulse_cycle", 32'(pulse_cyc), 32'(exp_pulse));
    check("count", 32'(o_count), 32'(cnt));
    check("x_min", 32'(o_x_min), 32'(xmn));
    check("x_max", 32'(o_x_max), 32'(xmx));
    check("y_min", 32'(o_y_min), 32'(ymn));
    check("y_max", 32'(o_y_max), 32'(ymx));
    check("detected", 32'(o_detected), 32'(det));
    check("mask_drain", 32'(q.size()), 0);
`ifdef HSV_BBOX_CENTER_EN
    check("cx", 32'(o_cx), 32'(cx));
    check("cy", 32'(o_cy), 32'(cy));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; i_valid = 1'b0; i_addr = '0; i_hue = '0; i_sat = '0; i_value = '0;
    i_cfg_load = 1'b0; i_cfg_hue_lo = '0; i_cfg_hue_hi = '0;
    i_cfg_sat_min = '0; i_cfg_val_min = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mask_we", 32'(o_mask_we), 0);
    check("rst_bbox_valid", 32'(o_bbox_valid), 0);
    check("rst_count", 32'(o_count), 0);
    check("rst_x_max", 32'(o_x_max), 0);
    check("rst_y_max", 32'(o_y_max), 0);
    check("rst_detected", 32'(o_detected), 0);
    rstn = 1'b1;

    // Default window: everything passes
    pulse_cnt = 0;
    for (int a = 0; a < 64; a++) pix(a, a * 300, 6400, 6400, 1'b1, 1'b0);
    frame_result(64, 0, 7, 0, 7, 1'b1, 3, 3);

    // Narrow window, hits only at 18,19,26,27; inclusive limits at 27
    cfg(7680, 8320, 3200, 3200);
    pulse_cnt = 0;
    for (int a = 0; a < 64; a++) begin
      case (a)
        18, 19, 26: pix(a, 7900, 6400, 6400, 1'b1, 1'b0);
        27:         pix(a, 8320, 3200, 3200, 1'b1, 1'b0);
        40:         pix(a, 7900, 3199, 6400, 1'b0, 1'b0);
        41:         pix(a, 7900, 6400, 3199, 1'b0, 1'b0);
        42:         pix(a, 7679, 6400, 6400, 1'b0, 1'b0);
        43:         pix(a, 8321, 6400, 6400, 1'b0, 1'b0);
        default:    pix(a, 0, 6400, 6400, 1'b0, 1'b0);
      endcase
    end
    frame_result(4, 2, 3, 2, 3, 1'b1, 2, 2);

    // Wrap-around window through 0
    cfg(22000, 640, 0, 0);
    pulse_cnt = 0;
    for (int a = 0; a < 64; a++) begin
      case (a)
        0:       pix(a, 23000, 6400, 6400, 1'b1, 1'b0);
        1:       pix(a, 100,   6400, 6400, 1'b1, 1'b0);
        2:       pix(a, 11520, 6400, 6400, 1'b0, 1'b0);
        3:       pix(a, 22000, 6400, 6400, 1'b1, 1'b0);
        4:       pix(a, 640,   6400, 6400, 1'b1, 1'b0);
        5:       pix(a, 21999, 6400, 6400, 1'b0, 1'b0);
        6:       pix(a, 641,   6400, 6400, 1'b0, 1'b0);
        default: pix(a, 0,     6400, 6400, 1'b1, 1'b0);
      endcase
    end
    frame_result(61, 0, 7, 0, 7, 1'b1, 3, 3);

    // Mid-frame load narrows the window; takes effect next frame only
    i_cfg_hue_lo = 16'd22000; i_cfg_hue_hi = 16'd100;
    i_cfg_sat_min = '0; i_cfg_val_min = '0;
    pulse_cnt = 0;
    for (int a = 0; a < 64; a++) pix(a, 300, 6400, 6400, 1'b1, a == 30);
    frame_result(64, 0, 7, 0, 7, 1'b1, 3, 3);

    // Load coincident with addr 0: old shadow (narrow) still applies
    i_cfg_hue_lo = 16'd0; i_cfg_hue_hi = 16'd23040;
    pulse_cnt = 0;
    for (int a = 0; a < 64; a++) pix(a, 300, 6400, 6400, 1'b0, a == 0);
    frame_result(0, 0, 0, 0, 0, 1'b0, 0, 0);

    // Truncated frame with hits, then a full frame with none
    cfg(22000, 100, 0, 0);
    pulse_cnt = 0;
    for (int a = 0; a <= 40; a++) pix(a, 23000, 6400, 6400, 1'b1, 1'b0);
    for (int a = 0; a < 64; a++) pix(a, 300, 6400, 6400, 1'b0, 1'b0);
    frame_result(0, 0, 0, 0, 0, 1'b0, 0, 0);

    // Gappy valid (1 of 3 cycles) over a full frame
    cfg(0, 23040, 0, 0);
    pulse_cnt = 0;
    for (int a = 0; a < 64; a++) begin
      pix(a, a * 300, 6400, 6400, 1'b1, 1'b0);
      idle(2);
    end
    frame_result(64, 0, 7, 0, 7, 1'b1, 3, 3);

    // Reset for one cycle at addr 20 of the next frame
    pulse_cnt = 0;
    for (int a = 0; a <= 20; a++) pix(a, 500, 6400, 6400, 1'b1, 1'b0);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    i_valid = 1'b0;
    q.delete();
    check("midrst_count", 32'(o_count), 0);
    check("midrst_x_max", 32'(o_x_max), 0);
    check("midrst_y_max", 32'(o_y_max), 0);
    check("midrst_detected", 32'(o_detected), 0);
    check("midrst_mask_we", 32'(o_mask_we), 0);
    for (int a = 21; a < 64; a++) pix(a, 500, 6400, 6400, 1'b1, 1'b0);
    idle(6);
    check("partial_no_pulse", 32'(pulse_cnt), 0);
    check("partial_count", 32'(o_count), 0);
    pulse_cnt = 0;
    for (int a = 0; a < 64; a++) pix(a, 500, 6400, 6400, 1'b1, 1'b0);
    frame_result(64, 0, 7, 0, 7, 1'b1, 3, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
